// File: rtl/image_scan_ctrl.sv
// Raster-scan address generator: walks one IMG_W x IMG_H frame per start pulse and
// presents addr/x/y over valid/ready. Define SCAN_BLANK_EN to insert HBLANK idle cycles between lines.
module image_scan_ctrl #(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int ADDR_W = 16,
    parameter int HBLANK = 4
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     start,
    input  logic                     ready,
    output logic                     valid,
    output logic [ADDR_W-1:0]        addr,
    output logic [$clog2(IMG_W)-1:0] x,
    output logic [$clog2(IMG_H)-1:0] y,
    output logic                     sof,
    output logic                     eol,
    output logic                     eof,
    output logic                     busy,
    output logic                     done
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    // Reject geometries the address counter cannot cover without wrapping.
    if (IMG_W < 2 || IMG_H < 2 || HBLANK < 1 ||
        (64'(1) << ADDR_W) < 64'(IMG_W * IMG_H)) begin : g_bad_params
        $error("image_scan_ctrl: illegal parameter set");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DONE  = 2'd2
`ifdef SCAN_BLANK_EN
        ,
        BLANK = 2'd3
`endif
    } state_t;

    state_t state;
    logic   accept;

`ifdef SCAN_BLANK_EN
    localparam int BW = (HBLANK > 1) ? $clog2(HBLANK) : 1;
    logic [BW-1:0] blank_cnt;
`endif

    // valid is a registered copy of (state == SCAN), so it doubles as the scan qualifier.
    assign accept = valid && ready;

    // NOTE: every register below uses <= so all next-state values derive from the same pre-edge state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            valid <= 1'b0;
            addr  <= '0;
            x     <= '0;
            y     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef SCAN_BLANK_EN
            blank_cnt <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SCAN;
                        valid <= 1'b1;
                        busy  <= 1'b1;
                        addr  <= '0;
                        x     <= '0;
                        y     <= '0;
                    end
                end
                SCAN: begin
                    if (accept) begin
                        if (x != X_LAST) begin
                            x    <= x + XW'(1);
                            addr <= addr + ADDR_W'(1);
                        end else if (y != Y_LAST) begin
                            x    <= '0;
                            y    <= y + YW'(1);
                            addr <= addr + ADDR_W'(1);
`ifdef SCAN_BLANK_EN
                            state     <= BLANK;
                            valid     <= 1'b0;
                            blank_cnt <= BW'(HBLANK - 1);
`endif
                        end else begin
                            // Last pixel: coordinates hold, done fires next cycle.
                            state <= DONE;
                            valid <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
`ifdef SCAN_BLANK_EN
                BLANK: begin
                    if (blank_cnt == '0) begin
                        state <= SCAN;
                        valid <= 1'b1;
                    end else begin
                        blank_cnt <= blank_cnt - BW'(1);
                    end
                end
`endif
                DONE: begin
                    // start is deliberately not sampled here.
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sof = valid && (x == '0) && (y == '0);
    assign eol = valid && (x == X_LAST);
    assign eof = eol && (y == Y_LAST);

endmodule

// File: tb/tb_image_scan_ctrl.sv
// Scoreboard bench for image_scan_ctrl (4x3 frame, HBLANK=2); build with or without SCAN_BLANK_EN.
// Stimulus pushes expected beats; a negedge monitor pops and compares every accepted beat.
module tb_image_scan_ctrl;

    localparam int IMG_W  = 4;
    localparam int IMG_H  = 3;
    localparam int ADDR_W = 8;
    localparam int HBLANK = 2;
`ifdef SCAN_BLANK_EN
    localparam int EXP_BUSY = 17;
    localparam int EXP_GAPS = 4;
`else
    localparam int EXP_BUSY = 13;
    localparam int EXP_GAPS = 0;
`endif

    logic              CLK;
    logic              RST_N;
    logic              start;
    logic              ready;
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        x;
    logic [1:0]        y;
    logic              sof, eol, eof, busy, done;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [1:0]        x;
        logic [1:0]        y;
        logic              sof;
        logic              eol;
        logic              eof;
    } beat_t;

    beat_t exp_q[$];
    int    checks     = 0;
    int    failures   = 0;
    int    busy_total = 0;
    int    done_total = 0;
    int    gap_total  = 0;

    image_scan_ctrl #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .ADDR_W(ADDR_W),
        .HBLANK(HBLANK)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .start(start),
        .ready(ready),
        .valid(valid),
        .addr (addr),
        .x    (x),
        .y    (y),
        .sof  (sof),
        .eol  (eol),
        .eof  (eof),
        .busy (busy),
        .done (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] outs();
        return {45'd0, valid, addr, x, y, sof, eol, eof, busy, done};
    endfunction

    function automatic logic gap_allowed(input logic [ADDR_W-1:0] a);
`ifdef SCAN_BLANK_EN
        return (a == ADDR_W'(3)) || (a == ADDR_W'(7));
`else
        return (a != a);
`endif
    endfunction

    // Hand-derived raster order for a 4x3 frame, optionally truncated.
    task automatic push_frame(input int n_beats);
        beat_t b;
        for (int i = 0; i < n_beats; i++) begin
            b.addr = ADDR_W'(i);
            b.x    = 2'(i % IMG_W);
            b.y    = 2'(i / IMG_W);
            b.sof  = (i == 0);
            b.eol  = (i % IMG_W) == IMG_W - 1;
            b.eof  = (i == IMG_W * IMG_H - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: scoreboard pops, stall hold, done timing and blank-gap placement.
    logic              prev_stall = 1'b0;
    logic              prev_eof_acc = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [1:0]        prev_x = '0, prev_y = '0;
    logic [ADDR_W-1:0] last_acc = '0;

    always @(negedge CLK) begin
        beat_t e;
        if (!RST_N) begin
            prev_stall   = 1'b0;
            prev_eof_acc = 1'b0;
        end else begin
            if (busy) busy_total++;
            if (done) done_total++;
            if (prev_eof_acc || done) check("done_after_eof", done, prev_eof_acc);
            if (busy && !valid && !done) begin
                gap_total++;
                check("gap_position", gap_allowed(last_acc), 1);
                check("gap_markers", {sof, eol, eof}, 3'b000);
            end
            if (prev_stall) begin
                check("hold_valid", valid, 1);
                check("hold_coord", {addr, x, y}, {prev_addr, prev_x, prev_y});
            end
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", {addr, x, y, sof, eol, eof},
                          {e.addr, e.x, e.y, e.sof, e.eol, e.eof});
                end
                last_acc     = addr;
                prev_eof_acc = eof;
            end else begin
                prev_eof_acc = 1'b0;
            end
            prev_stall = valid && !ready;
            prev_addr  = addr;
            prev_x     = x;
            prev_y     = y;
        end
    end

    task automatic run_frame(input bit toggle_ready, input bit poke_start);
        int b0, d0, g0;
        bit seen_done;
        b0 = busy_total;
        d0 = done_total;
        g0 = gap_total;
        push_frame(IMG_W * IMG_H);
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_latency", {valid, sof, busy, addr}, {3'b111, ADDR_W'(0)});
        seen_done = 1'b0;
        for (int k = 0; k < 300 && !seen_done; k++) begin
            start = 1'b0;
            ready = toggle_ready ? (k % 3 == 0) : 1'b1;
            if (poke_start && valid && addr == ADDR_W'(5)) start = 1'b1;
            tick();
            if (done) begin
                seen_done = 1'b1;
                start = poke_start;
                tick();
                start = 1'b0;
            end
        end
        check("done_seen", seen_done, 1);
        check("idle_after_done", {busy, valid}, 2'b00);
        tick();
        tick();
        check("still_idle", {busy, valid}, 2'b00);
        check("queue_drained", exp_q.size(), 0);
        check("done_pulses", done_total - d0, 1);
        check("blank_gaps", gap_total - g0, EXP_GAPS);
        if (!toggle_ready) check("busy_cycles", busy_total - b0, EXP_BUSY);
    endtask

    initial begin
        RST_N = 1'b0;
        start = 1'b0;
        ready = 1'b0;
        #12;
        check("reset_outputs", outs(), 0);
        tick();
        RST_N = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_no_start", outs(), 0);
        end

        run_frame(1'b0, 1'b0);
        run_frame(1'b1, 1'b0);
        run_frame(1'b0, 1'b1);

        // Mid-frame reset at addr 6: beats 0..5 are accepted, beat 6 never is.
        push_frame(6);
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 50 && !(valid && addr == ADDR_W'(6)); k++) tick();
        check("reached_addr6", addr, 6);
        RST_N = 1'b0;
        #1;
        check("midframe_reset_outputs", outs(), 0);
        check("midframe_queue", exp_q.size(), 0);
        tick();
        tick();
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_after_reset", outs(), 0);
        end

        run_frame(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
